// File: rtl/pb_uart_tx.sv
// pb_uart_tx: transmit half of the PicoBlaze UART.
// Bytes from the CPU land in a circular FIFO. An FSM pops them and shifts
// them out LSB first on tx, one bit per (uart_clock_divide+1) clocks.
// Optional feature macro: PB_UART_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit. Ports are the same either way.
// Handshake: buffer_write is a one-cycle push strobe with no ready; a push
// while the FIFO is full is dropped and reported by a one-cycle tx_overflow.
module pb_uart_tx #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        buffer_write,
  input  logic [7:0]  uart_data_write,
  input  logic        enable,
  input  logic [15:0] uart_clock_divide,
  output logic        tx,
  output logic        tx_data_present,
  output logic        tx_half_full,
  output logic        tx_full,
  output logic        tx_busy,
  output logic        tx_overflow
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] HALF_CNT = (ADDR_WIDTH+1)'(DEPTH/2);

  // FIFO storage (no reset: contents are meaningless until written)
  logic [7:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  present_q, present_d;
  logic                  half_q, half_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
`ifdef PB_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       bit_end;
  logic       can_pop;
  logic [7:0] head;

  // Debug probe: current FSM state, for binding checkers
  state_t dbg_state;
  assign dbg_state = state_q;

  // Write port of the FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_data_write;
  end

  // FIFO pointers, count and registered status flags
  always_comb begin
    push       = buffer_write && (count_q != FULL_CNT);
    overflow_d = buffer_write && (count_q == FULL_CNT);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (push && !pop)      count_d = count_q + (ADDR_WIDTH+1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_WIDTH+1)'(1);
    // Flags follow the count as it will be after this edge
    present_d = (count_d != '0);
    half_d    = (count_d >= HALF_CNT);
    full_d    = (count_d == FULL_CNT);
  end

  // Frame sequencer: baud counter, bit index, shift register, tx level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef PB_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    head    = mem_q[rd_ptr_q];
    can_pop = enable && (count_q != '0);
    // Divide compared live, so a smaller value mid-bit lets the counter wrap
    bit_end = (baud_q == uart_clock_divide);

    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = ST_START;
`ifdef PB_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef PB_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef PB_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits
          if (can_pop) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
`ifdef PB_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next state, so inputs never reach it directly
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef PB_UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State and status registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      present_q  <= 1'b0;
      half_q     <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef PB_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      present_q  <= present_d;
      half_q     <= half_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef PB_UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx              = tx_q;
  assign tx_data_present = present_q;
  assign tx_half_full    = half_q;
  assign tx_full         = full_q;
  assign tx_overflow     = overflow_q;
  assign tx_busy         = (dbg_state != ST_IDLE);

endmodule

// File: tb/tb_pb_uart_tx.sv
// Testbench for pb_uart_tx: random bytes, expected frames built from the
// serial framing rules (start, 8 data LSB first, optional parity, stop).
module tb_pb_uart_tx;

  localparam int DEPTH = 16;
`ifdef PB_UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = PAR ? 11 : 10;

  logic        clk;
  logic        reset;
  logic        buffer_write;
  logic [7:0]  uart_data_write;
  logic        enable;
  logic [15:0] uart_clock_divide;
  logic        tx;
  logic        tx_data_present;
  logic        tx_half_full;
  logic        tx_full;
  logic        tx_busy;
  logic        tx_overflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  pb_uart_tx #(.DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .buffer_write      (buffer_write),
    .uart_data_write   (uart_data_write),
    .enable            (enable),
    .uart_clock_divide (uart_clock_divide),
    .tx                (tx),
    .tx_data_present   (tx_data_present),
    .tx_half_full      (tx_half_full),
    .tx_full           (tx_full),
    .tx_busy           (tx_busy),
    .tx_overflow       (tx_overflow)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected level of bit k of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Receiver: waits (bounded) for a start bit, samples mid-bit, and ends
  // positioned on the first sample after the frame
  task automatic rx_byte(input int p, output logic [7:0] b, output logic par,
                         output logic stp, output bit ok);
    int t;
    int k;
    t = 0; b = '0; par = 1'b0; stp = 1'b0;
    while (tx !== 1'b0 && t < 4000) begin
      step();
      t++;
    end
    ok = (tx === 1'b0);
    if (ok) begin
      for (int s = 0; s < FB * p; s++) begin
        if ((s % p) == (p / 2)) begin
          k = s / p;
          if (k >= 1 && k <= 8) b[k-1] = tx;
          else if (PAR && k == 9) par = tx;
          else if (k == FB - 1) stp = tx;
        end
        step();
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_data_present !== 1'b0) begin failures++; $display("FAIL reset_present got=%b exp=0", tx_data_present); end
    checks++; if (tx_half_full !== 1'b0) begin failures++; $display("FAIL reset_half got=%b exp=0", tx_half_full); end
    checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", tx_full); end
    checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", tx_overflow); end
    step();
    step();
    reset = 1'b1;
    step();
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL post_reset_tx got=%b exp=1", tx); end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    b = 8'hA5;
    uart_clock_divide = 16'd3;
    enable = 1'b1;
    buffer_write = 1'b1; uart_data_write = b;
    step();
    buffer_write = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_start got=%b exp=1", tx); end
    step();
    for (int i = 0; i < FB * 4; i++) begin
      checks++; if (tx !== exp_bit(b, i / 4)) begin failures++; $display("FAIL single_tx clk=%0d got=%b exp=%b", i, tx, exp_bit(b, i / 4)); end
      checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy clk=%0d got=%b exp=1", i, tx_busy); end
      step();
    end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", tx_busy); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_idle_tx got=%b exp=1", tx); end
  endtask

  task automatic test_back_to_back();
    logic e;
    uart_clock_divide = 16'd0;
    enable = 1'b1;
    buffer_write = 1'b1; uart_data_write = 8'h00;
    step();
    uart_data_write = 8'hFF;
    step();
    buffer_write = 1'b0;
    for (int i = 0; i < 2 * FB; i++) begin
      e = (i < FB) ? exp_bit(8'h00, i) : exp_bit(8'hFF, i - FB);
      checks++; if (tx !== e) begin failures++; $display("FAIL b2b_tx clk=%0d got=%b exp=%b", i, tx, e); end
      checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy clk=%0d got=%b exp=1", i, tx_busy); end
      if (i == FB - 1) begin
        checks++; if (tx_data_present !== 1'b1) begin failures++; $display("FAIL b2b_present_held got=%b exp=1", tx_data_present); end
      end
      if (i == FB) begin
        checks++; if (tx_data_present !== 1'b0) begin failures++; $display("FAIL b2b_present_clear got=%b exp=0", tx_data_present); end
      end
      step();
    end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
  endtask

  task automatic test_full_overflow();
    int cnt;
    int prev;
    logic [7:0] b, got, e;
    logic par, stp;
    bit ok;
    enable = 1'b0;
    uart_clock_divide = 16'd1;
    cnt = 0;
    buffer_write = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      b = 8'($urandom_range(0, 255));
      uart_data_write = b;
      prev = cnt;
      if (cnt < DEPTH) begin
        exp_q.push_back(b);
        cnt++;
      end
      step();
      checks++; if (tx_data_present !== (cnt != 0)) begin failures++; $display("FAIL fill_present n=%0d got=%b exp=%b", k, tx_data_present, cnt != 0); end
      checks++; if (tx_half_full !== (cnt >= DEPTH / 2)) begin failures++; $display("FAIL fill_half n=%0d got=%b exp=%b", k, tx_half_full, cnt >= DEPTH / 2); end
      checks++; if (tx_full !== (cnt == DEPTH)) begin failures++; $display("FAIL fill_full n=%0d got=%b exp=%b", k, tx_full, cnt == DEPTH); end
      checks++; if (tx_overflow !== (prev == DEPTH)) begin failures++; $display("FAIL fill_overflow n=%0d got=%b exp=%b", k, tx_overflow, prev == DEPTH); end
    end
    buffer_write = 1'b0;
    step();
    checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL overflow_pulse got=%b exp=0", tx_overflow); end
    checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL full_held got=%b exp=1", tx_full); end
    enable = 1'b1;
    for (int f = 0; f < DEPTH; f++) begin
      rx_byte(2, got, par, stp, ok);
      e = exp_q.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL full_rx_timeout frame=%0d got=none exp=start", f); end
      checks++; if (got !== e) begin failures++; $display("FAIL full_rx_data frame=%0d got=%h exp=%h", f, got, e); end
      checks++; if (stp !== 1'b1) begin failures++; $display("FAIL full_rx_stop frame=%0d got=%b exp=1", f, stp); end
`ifdef PB_UART_TX_PARITY_EN
      checks++; if (par !== ^e) begin failures++; $display("FAIL full_rx_parity frame=%0d got=%b exp=%b", f, par, ^e); end
`endif
    end
    checks++; if (tx_data_present !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", tx_data_present); end
  endtask

  task automatic test_enable_gating();
    logic [7:0] b1, b2, got;
    logic par, stp;
    bit ok;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    uart_clock_divide = 16'd1;
    enable = 1'b1;
    buffer_write = 1'b1; uart_data_write = 8'h3C;
    step();
    uart_data_write = b1;
    step();
    for (int i = 0; i < FB * 2; i++) begin
      if (i == 0) uart_data_write = b2;
      if (i == 1) buffer_write = 1'b0;
      if (i == 3) enable = 1'b0;
      checks++; if (tx !== exp_bit(8'h3C, i / 2)) begin failures++; $display("FAIL gate_tx clk=%0d got=%b exp=%b", i, tx, exp_bit(8'h3C, i / 2)); end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL gate_idle_tx clk=%0d got=%b exp=1", i, tx); end
      checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL gate_idle_busy clk=%0d got=%b exp=0", i, tx_busy); end
      checks++; if (tx_data_present !== 1'b1) begin failures++; $display("FAIL gate_idle_present clk=%0d got=%b exp=1", i, tx_data_present); end
      step();
    end
    enable = 1'b1;
    step();
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL gate_restart got=%b exp=0", tx); end
    rx_byte(2, got, par, stp, ok);
    checks++; if (!ok || got !== b1) begin failures++; $display("FAIL gate_rx1 got=%h exp=%h", got, b1); end
    rx_byte(2, got, par, stp, ok);
    checks++; if (!ok || got !== b2) begin failures++; $display("FAIL gate_rx2 got=%h exp=%h", got, b2); end
    checks++; if (tx_data_present !== 1'b0) begin failures++; $display("FAIL gate_drained got=%b exp=0", tx_data_present); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] a, b, got;
    logic par, stp;
    bit ok;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    uart_clock_divide = 16'd2;
    enable = 1'b0;
    buffer_write = 1'b1; uart_data_write = a;
    step();
    buffer_write = 1'b0;
    checks++; if (tx_data_present !== 1'b1) begin failures++; $display("FAIL simul_one got=%b exp=1", tx_data_present); end
    enable = 1'b1;
    buffer_write = 1'b1; uart_data_write = b;
    step();
    buffer_write = 1'b0;
    checks++; if (tx_data_present !== 1'b1) begin failures++; $display("FAIL simul_present got=%b exp=1", tx_data_present); end
    checks++; if (tx_half_full !== 1'b0) begin failures++; $display("FAIL simul_half got=%b exp=0", tx_half_full); end
    rx_byte(3, got, par, stp, ok);
    checks++; if (!ok || got !== a) begin failures++; $display("FAIL simul_rx1 got=%h exp=%h", got, a); end
    rx_byte(3, got, par, stp, ok);
    checks++; if (!ok || got !== b) begin failures++; $display("FAIL simul_rx2 got=%h exp=%h", got, b); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL simul_idle got=%b exp=0", tx_busy); end
  endtask

  task automatic test_random();
    int n, p;
    logic [7:0] b, got, e;
    logic par, stp;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      p = $urandom_range(1, 4);
      n = $urandom_range(2, 6);
      uart_clock_divide = 16'(p - 1);
      enable = 1'b0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        buffer_write = 1'b1; uart_data_write = b;
        exp_q.push_back(b);
        step();
      end
      buffer_write = 1'b0;
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
        rx_byte(p, got, par, stp, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || got !== e) begin failures++; $display("FAIL rand_rx round=%0d frame=%0d got=%h exp=%h", r, k, got, e); end
        checks++; if (stp !== 1'b1) begin failures++; $display("FAIL rand_stop round=%0d frame=%0d got=%b exp=1", r, k, stp); end
`ifdef PB_UART_TX_PARITY_EN
        checks++; if (par !== ^e) begin failures++; $display("FAIL rand_parity round=%0d frame=%0d got=%b exp=%b", r, k, par, ^e); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    uart_clock_divide = 16'd3;
    enable = 1'b1;
    buffer_write = 1'b1; uart_data_write = 8'h00;
    step();
    step();
    buffer_write = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_pre_tx got=%b exp=0", tx); end
    checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL mid_pre_busy got=%b exp=1", tx_busy); end
    checks++; if (tx_data_present !== 1'b1) begin failures++; $display("FAIL mid_pre_present got=%b exp=1", tx_data_present); end
    #3 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_data_present !== 1'b0) begin failures++; $display("FAIL mid_reset_present got=%b exp=0", tx_data_present); end
    checks++; if (tx_half_full !== 1'b0) begin failures++; $display("FAIL mid_reset_half got=%b exp=0", tx_half_full); end
    checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL mid_reset_full got=%b exp=0", tx_full); end
    checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_overflow got=%b exp=0", tx_overflow); end
    step();
    reset = 1'b1;
    step();
    step();
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_after_tx got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL mid_after_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_data_present !== 1'b0) begin failures++; $display("FAIL mid_after_present got=%b exp=0", tx_data_present); end
  endtask

  initial begin
    reset = 1'b1;
    buffer_write = 1'b0;
    uart_data_write = 8'h00;
    enable = 1'b0;
    uart_clock_divide = 16'd0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_overflow();
    test_enable_gating();
    test_simultaneous();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
